// File: rtl/sda_gmem_read_boundary_splitter.sv
// AXI4 read-channel splitter: breaks INCR bursts at 4 KB pages and
// merges the returning R stream back to one RLAST per original request.
module sda_gmem_read_boundary_splitter #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0] DEPTH = (PW+1)'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [8:0]            total;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  ar_final;

    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [PW:0]                count;

    logic [12:0] off13;
    logic [12:0] btb;
    logic [12:0] btb_m1;
    logic [8:0]  total_m1;
    logic        fits;
    logic [7:0]  sub_len;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    // Beats left before the next 4 KB page for the current sub-burst start
    assign off13    = {1'b0, cur_addr[11:0]};
    assign btb      = (13'h1000 >> size_q) - (off13 >> size_q);
    assign btb_m1   = btb - 13'd1;
    assign total_m1 = total - 9'd1;
    assign fits     = (burst_q != 2'b01) || ({4'b0, total} <= btb);
    assign sub_len  = fits ? total_m1[7:0] : btb_m1[7:0];

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign push  = m_arvalid & m_arready;
    assign pop   = m_rvalid & s_rready & m_rlast & ~empty;

    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rid    = m_rid;
    assign s_rvalid = m_rvalid;
    assign m_rready = s_rready;
    assign s_rlast  = empty ? m_rlast : (m_rlast & fifo_q[rd_ptr]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s_arready <= 1'b0;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
            m_arid    <= '0;
            cur_addr  <= '0;
            total     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            ar_final  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_arvalid && s_arready) begin
                        cur_addr  <= s_araddr;
                        total     <= {1'b0, s_arlen} + 9'd1;
                        size_q    <= s_arsize;
                        burst_q   <= s_arburst;
                        id_q      <= s_arid;
                        s_arready <= 1'b0;
                        state     <= ISSUE;
                    end else begin
                        s_arready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (m_arvalid) begin
                        if (m_arready) begin
                            m_arvalid <= 1'b0;
                            if (ar_final) begin
                                state     <= IDLE;
                                s_arready <= 1'b1;
                            end else begin
                                cur_addr <= {cur_addr[ADDR_WIDTH-1:12] + 1'b1, 12'h000};
                                total    <= total - btb[8:0];
                            end
                        end
                    end else if (!full) begin
                        m_arvalid <= 1'b1;
                        m_araddr  <= cur_addr;
                        m_arlen   <= sub_len;
                        m_arsize  <= size_q;
                        m_arburst <= burst_q;
                        m_arid    <= id_q;
                        ar_final  <= fits;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-order record of which sub-bursts close an original request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= ar_final;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_sda_gmem_read_boundary_splitter.sv
// Randomized scoreboard bench for the 4 KB read boundary splitter.
module tb_sda_gmem_read_boundary_splitter;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int IW = 1;
    localparam int MO = 2;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        id;
    } ar_t;

    typedef struct {
        logic last;
        logic id;
    } rexp_t;

    typedef struct {
        int   len;
        logic id;
    } rpend_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] s_araddr = '0;
    logic [7:0]    s_arlen = '0;
    logic [2:0]    s_arsize = '0;
    logic [1:0]    s_arburst = '0;
    logic [IW-1:0] s_arid = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast;
    logic [IW-1:0] s_rid;
    logic          s_rvalid;
    logic          s_rready = 1'b0;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic [IW-1:0] m_arid;
    logic          m_arvalid;
    logic          m_arready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = '0;
    logic          m_rlast = 1'b0;
    logic [IW-1:0] m_rid = '0;
    logic          m_rvalid = 1'b0;
    logic          m_rready;

    always #5 clk = ~clk;

    sda_gmem_read_boundary_splitter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arid(s_arid), .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arid(m_arid), .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rid(m_rid), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int     npass = 0;
    int     ntotal = 0;
    int     ar_mode = 0;
    int     rr_mode = 0;
    bit     rhold = 1'b0;
    int     ar_hs_cnt = 0;
    ar_t    ar_exp[$];
    rexp_t  r_exp[$];
    rpend_t r_pend[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: split by byte arithmetic on page ends
    task automatic model(logic [63:0] a0, logic [7:0] l, logic [2:0] sz,
                         logic [1:0] b, logic i);
        ar_t e;
        longint unsigned a, rem, bs, fit, n;
        e.size = sz; e.burst = b; e.id = i;
        if (b != 2'b01) begin
            e.addr = a0; e.len = l;
            ar_exp.push_back(e);
        end else begin
            a = a0; rem = longint'(l) + 1; bs = longint'(1) << sz;
            while (rem > 0) begin
                fit = (4096 - (a % 4096) + bs - 1) / bs;
                n = (rem < fit) ? rem : fit;
                e.addr = a; e.len = 8'(n - 1);
                ar_exp.push_back(e);
                rem -= n;
                a = (a / 4096 + 1) * 4096;
            end
        end
        for (int k = 0; k <= int'(l); k++) begin
            rexp_t r;
            r.last = (k == int'(l)); r.id = i;
            r_exp.push_back(r);
        end
    endtask

    task automatic send(logic [63:0] a, logic [7:0] l, logic [2:0] sz,
                        logic [1:0] b, logic i);
        bit hs;
        int n = 0;
        s_araddr = a; s_arlen = l; s_arsize = sz;
        s_arburst = b; s_arid = i; s_arvalid = 1'b1;
        do begin
            @(negedge clk); hs = s_arready;
            @(posedge clk); #1; n++;
        end while (!hs && n < 5000);
        s_arvalid = 1'b0;
        if (!hs) begin
            ntotal++;
            $display("FAIL ar_accept timeout addr=%0h", a);
        end else begin
            model(a, l, sz, b, i);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((ar_exp.size() != 0 || r_exp.size() != 0 ||
                r_pend.size() != 0 || m_rvalid) && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20000) begin
            ntotal++;
            $display("FAIL drain timeout ar=%0d r=%0d", ar_exp.size(), r_exp.size());
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            m_arready = (ar_mode == 0) ? ($urandom_range(0, 2) != 0) : (ar_mode == 2);
            s_rready  = (rr_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Downstream slave: returns each accepted sub-burst in order
    initial begin
        rpend_t e;
        bit hs;
        forever begin
            @(posedge clk); #1;
            if (r_pend.size() != 0 && !rhold) begin
                e = r_pend.pop_front();
                for (int k = 0; k <= e.len; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    m_rvalid = 1'b1; m_rdata = $urandom;
                    m_rresp = 2'($urandom); m_rid = e.id;
                    m_rlast = (k == e.len);
                    do begin
                        @(negedge clk); hs = m_rready;
                        @(posedge clk); #1;
                    end while (!hs);
                    m_rvalid = 1'b0; m_rlast = 1'b0;
                end
            end
        end
    end

    logic        prev_v = 1'b0;
    logic [63:0] prev_addr;
    logic [7:0]  prev_len;

    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v) begin
                chk("ar_hold_valid", 64'(m_arvalid), 64'd1);
                chk("ar_hold_addr", m_araddr, prev_addr);
                chk("ar_hold_len", 64'(m_arlen), 64'(prev_len));
            end
            prev_v = m_arvalid && !m_arready;
            prev_addr = m_araddr; prev_len = m_arlen;
            if (m_arvalid && m_arready) begin
                rpend_t p;
                ar_hs_cnt++;
                p.len = int'(m_arlen); p.id = m_arid;
                r_pend.push_back(p);
                if (ar_exp.size() == 0) begin
                    ntotal++;
                    $display("FAIL ar_unexpected addr=%0h len=%0d", m_araddr, m_arlen);
                end else begin
                    ar_t e;
                    e = ar_exp.pop_front();
                    chk("ar_addr", m_araddr, e.addr);
                    chk("ar_len", 64'(m_arlen), 64'(e.len));
                    chk("ar_size", 64'(m_arsize), 64'(e.size));
                    chk("ar_burst", 64'(m_arburst), 64'(e.burst));
                    chk("ar_id", 64'(m_arid), 64'(e.id));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && s_rvalid && s_rready) begin
            if (r_exp.size() == 0) begin
                ntotal++;
                $display("FAIL r_unexpected rlast=%0b", s_rlast);
            end else begin
                rexp_t e;
                e = r_exp.pop_front();
                chk("r_last", 64'(s_rlast), 64'(e.last));
                chk("r_id", 64'(s_rid), 64'(e.id));
                chk("r_data", 64'(s_rdata), 64'(m_rdata));
                chk("r_resp", 64'(s_rresp), 64'(m_rresp));
            end
        end
    end

    initial begin
        int n;
        int c0;
        logic [63:0] a0;
        logic [7:0]  l0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_arready", 64'(s_arready), 64'd0);
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_m_araddr", m_araddr, 64'd0);
        chk("rst_m_arlen", 64'(m_arlen), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rel_s_arready", 64'(s_arready), 64'd1);

        send(64'h0FF0, 8'd7, 3'd2, 2'b01, 1'b0);
        drain();

        ar_mode = 2;
        send(64'h0100, 8'd15, 3'd2, 2'b01, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(m_arvalid && m_arready) && n < 100);
        @(posedge clk); #1;
        chk("arready_after_single", 64'(s_arready), 64'd1);
        drain();

        ar_mode = 0;
        send(64'h0FF0, 8'd7, 3'd2, 2'b00, 1'b0);
        drain();

        ar_mode = 2; rr_mode = 1; rhold = 1'b1;
        c0 = ar_hs_cnt;
        send(64'h0F00, 8'd255, 3'd5, 2'b01, 1'b0);
        repeat (20) @(negedge clk);
        chk("full_ar_count", 64'(ar_hs_cnt - c0), 64'd2);
        chk("full_arvalid_low", 64'(m_arvalid), 64'd0);
        rhold = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(m_rvalid && m_rready && m_rlast) && n < 200);
        @(negedge clk);
        @(negedge clk);
        chk("third_ar_after_pop", 64'(m_arvalid), 64'd1);
        chk("third_ar_addr", m_araddr, 64'h2000);
        drain();
        ar_mode = 0; rr_mode = 0;

        for (int t = 0; t < 40; t++) begin
            logic [63:0] a;
            logic [1:0]  b;
            a = {32'h0, $urandom};
            if ($urandom_range(0, 1) == 1) a[11:8] = 4'hF;
            b = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b01;
            send(a, 8'($urandom), 3'($urandom_range(0, 5)), b, 1'($urandom));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        ar_mode = 1;
        send(64'h0FF0, 8'd7, 3'd2, 2'b01, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end
        while (!m_arvalid && n < 100);
        a0 = m_araddr; l0 = m_arlen;
        chk("stall_first_addr", a0, 64'h0FF0);
        chk("stall_first_len", 64'(l0), 64'd3);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 64'(m_arvalid), 64'd1);
            chk("stall_addr", m_araddr, a0);
        end
        rhold = 1'b1;
        c0 = ar_hs_cnt;
        ar_mode = 2;
        n = 0;
        while (ar_hs_cnt - c0 < 2 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_arvalid", 64'(m_arvalid), 64'd0);
        chk("midrst_arready", 64'(s_arready), 64'd0);
        ar_exp.delete(); r_exp.delete(); r_pend.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("postrst_arready", 64'(s_arready), 64'd1);
        chk("postrst_arvalid", 64'(m_arvalid), 64'd0);
        rhold = 1'b0; ar_mode = 0;
        send(64'h0100, 8'd15, 3'd2, 2'b01, 1'b0);
        drain();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
